// File: rtl/adder_pkg.sv
// Shared definitions for the sequential multi-operand adder.
// Holds the control FSM state encoding used by seq_multi_operand_adder.
package adder_pkg;

    // IDLE : waiting for the first beat of a transfer
    // ACCUM: transfer open, summing further beats
    // HOLD : result presented on out_*, waiting for the output handshake
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/rca_nbit.sv
// Ripple-carry adder, N bits wide, built from a chain of full adders.
// Ports:
//   A, B : N-bit addends
//   Cin  : carry into bit 0
//   S    : N+1-bit result, S[N] is the carry out of the top bit
module rca_nbit #(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N:0]   S
);

    logic [N:0] carry;

    assign carry[0] = Cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign S[gi]        = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi+1]  = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign S[N] = carry[N];

endmodule

// File: rtl/seq_multi_operand_adder.sv
// Sequential multi-operand adder. Accepts a stream of unsigned operand beats
// (valid/ready), sums them plus a carry-in taken from the first beat, and
// presents the total, the operand count and an overflow-of-operands error
// flag on a valid/ready output port.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand beat handshake
//   in_data, in_last, cin : operand, end-of-transfer marker, carry-in (first beat only)
//   out_valid/out_ready   : result handshake
//   out_sum               : sum of all operands plus cin
//   out_count             : number of operands in the transfer
//   out_err               : transfer closed at MAX_OPS without in_last
module seq_multi_operand_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_OPS = 8,
    localparam int SUM_W  = WIDTH + $clog2(MAX_OPS),
    localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    state_t             state_reg, state_next;
    logic [SUM_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               err_reg, err_next;
    logic               valid_reg, valid_next;
    // Keeps in_ready low until the first edge after reset release.
    logic               ready_en_reg;

    logic               accept;
    logic               start;
    logic [SUM_W-1:0]   add_a;
    logic [SUM_W-1:0]   add_b;
    logic               add_cin;
    logic [SUM_W:0]     add_sum;
    logic [CNT_W-1:0]   count_inc;
    logic               at_max;
    logic               unused_carry;

    // Any beat accepted outside ACCUM opens a fresh transfer (from IDLE, or
    // from HOLD on the same edge that retires the previous result).
    assign accept  = in_valid && in_ready;
    assign start   = (state_reg != ACCUM);

    assign add_a   = start ? '0 : acc_reg;
    assign add_b   = SUM_W'(in_data);
    assign add_cin = start ? cin : 1'b0;

    rca_nbit #(
        .N   (SUM_W)
    ) u_rca (
        .A   (add_a),
        .B   (add_b),
        .Cin (add_cin),
        .S   (add_sum)
    );

    // SUM_W is sized so the carry out of the top bit is always zero.
    assign unused_carry = add_sum[SUM_W];

    assign count_inc = start ? CNT_W'(1) : count_reg + CNT_W'(1);
    assign at_max    = (count_inc == CNT_W'(MAX_OPS));

    always_comb begin
        in_ready   = 1'b0;
        state_next = state_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        err_next   = err_reg;
        valid_next = valid_reg;

        case (state_reg)
            IDLE:    in_ready = ready_en_reg;
            ACCUM:   in_ready = 1'b1;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase

        if (accept) begin
            acc_next   = add_sum[SUM_W-1:0];
            count_next = count_inc;
            err_next   = at_max && !in_last;
            if (in_last || at_max) begin
                state_next = HOLD;
                valid_next = 1'b1;
            end else begin
                state_next = ACCUM;
                valid_next = 1'b0;
            end
        end else if (state_reg == HOLD && out_ready) begin
            state_next = IDLE;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            count_reg    <= count_next;
            err_reg      <= err_next;
            valid_reg    <= valid_next;
            ready_en_reg <= 1'b1;
        end
    end

    // The accumulator registers double as the result registers: they only
    // change on an accepted beat, which in HOLD coincides with retirement.
    assign out_valid = valid_reg;
    assign out_sum   = acc_reg;
    assign out_count = count_reg;
    assign out_err   = err_reg;

endmodule

// File: doc/seq_multi_operand_adder.md
SEQ_MULTI_OPERAND_ADDER -- requirements
Module: seq_multi_operand_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 The block SHALL have parameter MAX_OPS, default 8, giving the maximum operands per transfer (legal range 2..256).
REQ-003 The block SHALL derive localparams SUM_W = WIDTH + $clog2(MAX_OPS) and CNT_W = $clog2(MAX_OPS+1).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block can accept an operand beat.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 in_last  input  1  marks the final operand of a transfer.
REQ-010 cin  input  1  carry-in; sampled only on the first beat of a transfer.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_sum  output  SUM_W  unsigned sum of all operands plus cin.
REQ-014 out_count  output  CNT_W  number of operands accepted in the transfer.
REQ-015 out_err  output  1  transfer closed at MAX_OPS without in_last.

Function
REQ-016 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-017 The FSM SHALL have states IDLE, ACCUM and HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0; an accepted beat loads acc = in_data + cin and count = 1, then moves to HOLD if in_last is set, else to ACCUM.
REQ-019 ACCUM: in_ready=1; an accepted beat does acc += in_data and count += 1, and cin is ignored.
REQ-020 ACCUM SHALL move to HOLD when the accepted beat has in_last=1 or count reaches MAX_OPS; reaching MAX_OPS without in_last sets out_err=1.
REQ-021 HOLD: out_valid=1; out_sum, out_count and out_err SHALL stay stable until the output handshake completes.
REQ-022 HOLD: in_ready SHALL equal out_ready (combinational path); with out_ready=0 no beat is accepted.
REQ-023 HOLD with out_ready=1 and in_valid=0 SHALL move to IDLE on the next edge.
REQ-024 HOLD with out_ready=1 and in_valid=1 SHALL retire the result and start a new transfer as in REQ-018 on the same edge.
REQ-025 out_valid SHALL rise on the edge that accepts the closing beat, one cycle after that beat is presented.
REQ-026 Sustained throughput SHALL be one operand per cycle while out_ready=1.
REQ-027 All arithmetic SHALL be unsigned and zero-extended to SUM_W; by construction no overflow is possible.
REQ-028 out_err SHALL clear when the next transfer starts.
REQ-029 An idle cycle (in_valid=0) in ACCUM SHALL hold all state.

Reset
REQ-030 While rst_n=0: state=IDLE, acc=0, count=0, out_valid=0, out_sum=0, out_count=0, out_err=0, in_ready=0.
REQ-031 Reset asserted mid-transfer SHALL discard the partial sum; the first transfer after release starts from zero.
REQ-032 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.

Structure
REQ-033 Package adder_pkg SHALL hold the FSM state enum typedef.
REQ-034 The adder datapath SHALL be one sub-module, rca_nbit: a ripple-carry adder parametrised by width, with inputs A, B, Cin and output S of width+1 bits.
REQ-035 The accumulator, counter and FSM SHALL be registered; out_* SHALL be driven from registers.

Verification
REQ-036 WIDTH=16, MAX_OPS=8; beats 0xFFFF, 0xFFFF, 0xFFFF(last), cin=1 -> out_sum=0x2FFFE, out_count=3, out_err=0.
REQ-037 Single beat 0x1234 with in_last=1, cin=0 -> out_valid on the next edge, out_sum=0x1234, out_count=1.
REQ-038 Eight beats of 0xFFFF with no in_last, cin=1 -> out_sum=0x7FFF9, out_count=8, out_err=1; a following beat starts a new transfer with out_err=0.
REQ-039 Beats 12345, 54321, 11111(last) with cin=1 on beat 2 only -> out_sum=77777 (0x12FD1), because cin is ignored after the first beat.
REQ-040 Hold out_ready=0 for 5 cycles in HOLD -> in_ready=0 and outputs stable; then out_ready=1 with in_valid=1 -> result retired and the new beat accepted on the same edge.
REQ-041 Assert rst_n=0 after 2 beats of 0x0001 -> all outputs 0; after release, beat 0x0005(last) with cin=0 -> out_sum=0x5.
